// File: rtl/instr_loader.sv
// Boot-time loader: length-prefixed byte stream -> byte-wide instruction memory writes.
// Optional trailing XOR checksum byte when CHECKSUM_EN is defined.
module instr_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [7:0]               mem_wdata_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     cpu_rst_o
);

  localparam int unsigned CAPACITY = 32'd1 << ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             len_lo_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   len_full;
  logic [ADDRESS_WIDTH:0] count_q;
  logic                   last_byte;
  logic                   len_zero;
  logic                   len_over;
`ifdef CHECKSUM_EN
  logic [7:0]             acc_q;
`endif

  assign len_full  = {rx_data_i, len_lo_q};
  assign len_zero  = (len_full == '0);
  assign len_over  = (32'(len_full) > CAPACITY);
  assign last_byte = ((32'(count_q) + 32'd1) == 32'(len_q));

  // The core is released only once DONE has been visible for a cycle with done set,
  // so the final payload write always lands before reset drops.
  assign cpu_rst_o = !((state_q == DONE) && done_o && !err_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rx_ready_o = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = LEN_LO;
      end
      LEN_LO: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (rx_valid_i) state_d = LEN_HI;
      end
      LEN_HI: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (rx_valid_i) begin
          if (len_zero) begin
`ifdef CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else if (len_over) begin
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (rx_valid_i && last_byte) begin
`ifdef CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (rx_valid_i) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_lo_q    <= '0;
      len_q       <= '0;
      count_q     <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
`ifdef CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      mem_we_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            count_q <= '0;
`ifdef CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        DONE: begin
          if (start_i) begin
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            count_q <= '0;
`ifdef CHECKSUM_EN
            acc_q   <= '0;
`endif
          end else begin
            // Arriving from DATA, done is raised one cycle after entering DONE.
            done_o <= 1'b1;
          end
        end
        LEN_LO: begin
          if (rx_valid_i) len_lo_q <= rx_data_i;
        end
        LEN_HI: begin
          if (rx_valid_i) begin
            len_q <= len_full;
            if (len_zero) begin
`ifndef CHECKSUM_EN
              done_o <= 1'b1;
`endif
            end else if (len_over) begin
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= count_q[ADDRESS_WIDTH-1:0];
            mem_wdata_o <= rx_data_i;
            count_q     <= count_q + 1'b1;
`ifdef CHECKSUM_EN
            acc_q       <= acc_q ^ rx_data_i;
`endif
          end
        end
`ifdef CHECKSUM_EN
        CHECK: begin
          if (rx_valid_i) begin
            done_o <= 1'b1;
            err_o  <= (rx_data_i != acc_q);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (ADDRESS_WIDTH = 8).
module tb_instr_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, mem_we, busy, done, err, cpu_rst;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prog [4] = '{8'h13, 8'h05, 8'hA0, 8'h00};

  always #5 clk = ~clk;

  instr_loader #(.ADDRESS_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .cpu_rst_o   (cpu_rst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic payload(input string tag, input int idx, input logic [7:0] b);
    xfer(b);
    check({tag, "_we"},   32'(mem_we),    32'd1);
    check({tag, "_addr"}, 32'(mem_addr),  32'(idx));
    check({tag, "_data"}, 32'(mem_wdata), 32'(b));
  endtask

  // Completes a good load after the last payload byte has been accepted.
  task automatic finish_good(input string tag);
`ifdef CHECKSUM_EN
    xfer(8'hB6);
    check({tag, "_done"},    32'(done),    32'd1);
    check({tag, "_err"},     32'(err),     32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
`else
    check({tag, "_done_n1"},    32'(done),    32'd0);
    check({tag, "_cpu_rst_n1"}, 32'(cpu_rst), 32'd1);
    step();
    check({tag, "_done"},    32'(done),    32'd1);
    check({tag, "_err"},     32'(err),     32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
`endif
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    step(); step();
    check("rst_ready",   32'(rx_ready),  32'd0);
    check("rst_we",      32'(mem_we),    32'd0);
    check("rst_addr",    32'(mem_addr),  32'd0);
    check("rst_wdata",   32'(mem_wdata), 32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_err",     32'(err),       32'd0);
    check("rst_cpu_rst", 32'(cpu_rst),   32'd1);
    rst = 1'b0;
    step();

    // Back-to-back stream
    pulse_start();
    check("s1_ready", 32'(rx_ready), 32'd1);
    check("s1_busy",  32'(busy),     32'd1);
    xfer(8'h04);
    xfer(8'h00);
    check("s1_no_we_hdr", 32'(mem_we), 32'd0);
    for (int i = 0; i < 4; i++) payload("s1", i, prog[i]);
    finish_good("s1");

    // Stalled stream, valid toggling
    pulse_start();
    xfer(8'h04); step();
    xfer(8'h00); step();
    for (int i = 0; i < 4; i++) begin
      payload("s2", i, prog[i]);
      step();
      check("s2_stall_we", 32'(mem_we), 32'd0);
    end
`ifdef CHECKSUM_EN
    check("s2_busy_chk", 32'(busy), 32'd1);
    finish_good("s2");
`else
    check("s2_done", 32'(done),    32'd1);
    check("s2_cpu",  32'(cpu_rst), 32'd0);
`endif

    // Oversize length 0x0101
    pulse_start();
    xfer(8'h01);
    xfer(8'h01);
    check("ov_done",  32'(done),     32'd1);
    check("ov_err",   32'(err),      32'd1);
    check("ov_we",    32'(mem_we),   32'd0);
    check("ov_cpu",   32'(cpu_rst),  32'd1);
    check("ov_ready", 32'(rx_ready), 32'd0);
    step();
    check("ov_cpu2",  32'(cpu_rst),  32'd1);
    check("ov_we2",   32'(mem_we),   32'd0);

    // Zero length
    pulse_start();
    check("z_err_clr", 32'(err), 32'd0);
    xfer(8'h00);
    xfer(8'h00);
    check("z_we", 32'(mem_we), 32'd0);
`ifdef CHECKSUM_EN
    check("z_busy", 32'(busy), 32'd1);
    xfer(8'h00);
`endif
    check("z_done", 32'(done), 32'd1);
    check("z_err",  32'(err),  32'd0);

    // Full-capacity length 0x0100
    pulse_start();
    xfer(8'h00);
    xfer(8'h01);
    for (int i = 0; i < 256; i++) begin
      xfer(8'(i ^ 8'h5A));
      if (i == 0 || i == 255) begin
        check("cap_we",   32'(mem_we),    32'd1);
        check("cap_addr", 32'(mem_addr),  32'(i));
        check("cap_data", 32'(mem_wdata), 32'(i ^ 8'h5A));
      end
    end
`ifdef CHECKSUM_EN
    xfer(8'h00);
`else
    step();
`endif
    check("cap_done", 32'(done), 32'd1);
    check("cap_err",  32'(err),  32'd0);

`ifdef CHECKSUM_EN
    // Bad checksum
    pulse_start();
    xfer(8'h04); xfer(8'h00);
    for (int i = 0; i < 4; i++) payload("bad", i, prog[i]);
    xfer(8'hB7);
    check("bad_done", 32'(done),    32'd1);
    check("bad_err",  32'(err),     32'd1);
    check("bad_cpu",  32'(cpu_rst), 32'd1);
`endif

    // Reset mid-load, then full reload
    pulse_start();
    xfer(8'h04); xfer(8'h00);
    payload("mr_a", 0, prog[0]);
    payload("mr_a", 1, prog[1]);
    rst = 1'b1;
    step();
    check("mr_busy",  32'(busy),     32'd0);
    check("mr_ready", 32'(rx_ready), 32'd0);
    check("mr_cpu",   32'(cpu_rst),  32'd1);
    rst = 1'b0;
    pulse_start();
    xfer(8'h04); xfer(8'h00);
    for (int i = 0; i < 4; i++) payload("mr_b", i, prog[i]);
    finish_good("mr_b");

    // start in DATA is ignored; start in DONE reloads
    pulse_start();
    xfer(8'h04); xfer(8'h00);
    payload("sd", 0, prog[0]);
    start = 1'b1;
    payload("sd", 1, prog[1]);
    start = 1'b0;
    check("sd_busy", 32'(busy), 32'd1);
    payload("sd", 2, prog[2]);
    payload("sd", 3, prog[3]);
    finish_good("sd");
    pulse_start();
    check("rl_done",  32'(done),     32'd0);
    check("rl_cpu",   32'(cpu_rst),  32'd1);
    check("rl_ready", 32'(rx_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
